// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I memory-access stage: EX/MEM and MEM/WB registers with data-memory handshake
module mem_wb_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_ALU_out,
  input  logic [31:0] ex_ForwardDataB,
  input  logic [1:0]  ex_MemOp,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_RegWEn,
  input  logic [1:0]  ex_WBSel,
  input  logic [31:0] ex_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic [31:0] mem_ALU_out,
  output logic [4:0]  mem_rd,
  output logic        mem_RegWEn,
  output logic [31:0] wb_WBData,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWEn,
  output logic        mem_misalign,
  output logic        mem_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic        mValid, mRegWEn, mBad;
  logic [31:0] mAlu, mStore, mPc;
  logic [1:0]  mMemOp, mWBSel;
  logic [2:0]  mF3;
  logic [4:0]  mRd;

  logic        wValid, wRegWEn;
  logic [31:0] wData;
  logic [4:0]  wRd;

  logic [CW-1:0] waitCnt;
  logic          misalignFlag, timeoutFlag;

  logic        exIsMem, exLegal, exAligned, exBad, exQualify;
  logic        busy, timeoutHit;
  logic [1:0]  off;
  logic [3:0]  storeStrb;
  logic [31:0] storeData, loadExt, loadData, wbNext;
  logic [7:0]  rdByte;
  logic [15:0] rdHalf;

  // Decode legality/alignment in EX so the request can start on the capture edge
  always_comb begin
    exIsMem = (ex_MemOp == 2'b01) || (ex_MemOp == 2'b10);
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: exLegal = 1'b1;
      3'b100, 3'b101:         exLegal = (ex_MemOp == 2'b01);
      default:                exLegal = 1'b0;
    endcase
    case (ex_funct3[1:0])
      2'b01:   exAligned = ~ex_ALU_out[0];
      2'b10:   exAligned = (ex_ALU_out[1:0] == 2'b00);
      default: exAligned = 1'b1;
    endcase
    exBad     = ~exLegal | ~exAligned;
    exQualify = ex_valid & exIsMem & ~exBad;
  end

  assign busy       = (state == BUSY);
  assign timeoutHit = busy & ~dmem_ready & (waitCnt == CW'(MAX_WAIT - 1));
  assign mem_stall  = busy & ~dmem_ready & ~timeoutHit;
  assign off        = mAlu[1:0];
  assign rdByte     = dmem_rdata[{off, 3'b000} +: 8];
  assign rdHalf     = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    storeStrb = 4'b1111;
    storeData = mStore;
    case (mF3[1:0])
      2'b00: begin
        storeStrb = 4'b0001 << off;
        storeData = {4{mStore[7:0]}};
      end
      2'b01: begin
        storeStrb = 4'b0011 << off;
        storeData = {2{mStore[15:0]}};
      end
      default: ;
    endcase
    case (mF3)
      3'b000:  loadExt = {{24{rdByte[7]}}, rdByte};
      3'b100:  loadExt = {24'h0, rdByte};
      3'b001:  loadExt = {{16{rdHalf[15]}}, rdHalf};
      3'b101:  loadExt = {16'h0, rdHalf};
      default: loadExt = dmem_rdata;
    endcase
    // A timed-out access returns zero because ready never arrived
    loadData = (busy && dmem_ready) ? loadExt : 32'h0;
    case (mWBSel)
      2'd0:    wbNext = loadData;
      2'd1:    wbNext = mAlu;
      2'd2:    wbNext = mPc + 32'd4;
      default: wbNext = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mValid       <= 1'b0;
      mRegWEn      <= 1'b0;
      mBad         <= 1'b0;
      mAlu         <= 32'h0;
      mStore       <= 32'h0;
      mPc          <= 32'h0;
      mMemOp       <= 2'b00;
      mWBSel       <= 2'b00;
      mF3          <= 3'b000;
      mRd          <= 5'd0;
      wValid       <= 1'b0;
      wRegWEn      <= 1'b0;
      wData        <= 32'h0;
      wRd          <= 5'd0;
      waitCnt      <= '0;
      misalignFlag <= 1'b0;
      timeoutFlag  <= 1'b0;
    end else begin
      if (!mem_stall) begin
        mValid  <= ex_valid;
        mRegWEn <= ex_RegWEn;
        mBad    <= exIsMem & exBad;
        mAlu    <= ex_ALU_out;
        mStore  <= ex_ForwardDataB;
        mPc     <= ex_pc;
        mMemOp  <= ex_MemOp;
        mWBSel  <= ex_WBSel;
        mF3     <= ex_funct3;
        mRd     <= ex_rd;
        wValid  <= mValid;
        wRegWEn <= mRegWEn & ~mBad & ~timeoutHit;
        wData   <= wbNext;
        wRd     <= mRd;
        state   <= exQualify ? BUSY : IDLE;
        waitCnt <= '0;
        if (ex_valid && exIsMem && exBad) misalignFlag <= 1'b1;
      end else begin
        waitCnt <= waitCnt + CW'(1);
      end
      if (timeoutHit) timeoutFlag <= 1'b1;
    end
  end

  assign dmem_req     = busy;
  assign dmem_we      = busy & (mMemOp == 2'b10);
  assign dmem_addr    = {mAlu[31:2], 2'b00};
  assign dmem_wdata   = storeData;
  assign dmem_wstrb   = dmem_we ? storeStrb : 4'b0000;
  assign mem_ALU_out  = mAlu;
  assign mem_rd       = mRd;
  assign mem_RegWEn   = mValid & mRegWEn;
  assign wb_WBData    = wData;
  assign wb_rd        = wRd;
  assign wb_RegWEn    = wValid & wRegWEn & (wRd != 5'd0);
  assign mem_misalign = misalignFlag;
  assign mem_timeout  = timeoutFlag;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - table-driven and scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_RegWEn, dmem_ready;
  logic [31:0] ex_ALU_out, ex_ForwardDataB, ex_pc, dmem_rdata;
  logic [1:0]  ex_MemOp, ex_WBSel;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, mem_stall, mem_RegWEn, wb_RegWEn, mem_misalign, mem_timeout;
  logic [31:0] dmem_addr, dmem_wdata, mem_ALU_out, wb_WBData;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  mem_rd, wb_rd;

  mem_wb_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ALU_out(ex_ALU_out),
    .ex_ForwardDataB(ex_ForwardDataB), .ex_MemOp(ex_MemOp), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn), .ex_WBSel(ex_WBSel), .ex_pc(ex_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .mem_ALU_out(mem_ALU_out), .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn),
    .wb_WBData(wb_WBData), .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn),
    .mem_misalign(mem_misalign), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  memOp;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        regWEn;
    logic [1:0]  wbSel;
    logic [31:0] pc;
    logic        expReq;
    logic        expWe;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic        expMis;
    logic        expWen;
    logic [31:0] expData;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  vec_t vecs[15];
  wb_t  expQ[$];
  int   nCmp = 0;
  int   nBad = 0;
  logic prevStall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    ex_valid        = valid;
    ex_MemOp        = v.memOp;
    ex_funct3       = v.f3;
    ex_ALU_out      = v.addr;
    ex_ForwardDataB = v.sdata;
    ex_rd           = v.rd;
    ex_RegWEn       = v.regWEn;
    ex_WBSel        = v.wbSel;
    ex_pc           = v.pc;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [4:0] rd, input logic [1:0] wbSel);
    vec_t v;
    v = '0;
    v.memOp = op; v.f3 = f3; v.addr = addr; v.rd = rd; v.regWEn = 1'b1; v.wbSel = wbSel; v.pc = 32'h200;
    return v;
  endfunction

  // Scoreboard: a write is new only if W captured at the previous edge
  always @(negedge clk) begin
    wb_t e;
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (wb_RegWEn && !prevStall) begin
        if (expQ.size() == 0) begin
          nCmp++;
          nBad++;
          $display("FAIL wb_unexpected: rd %0d data %h, no write expected", wb_rd, wb_WBData);
        end else begin
          e = expQ.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_WBData, e.data);
        end
      end
      prevStall = mem_stall;
    end
  end

  initial begin
    vec_t v;
    int   stallCnt;

    vecs[0]  = '{2'b01, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 1'b1, 2'd0, 32'h200, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[1]  = '{2'b01, 3'b000, 32'h103, 32'h0, 32'h80112233, 5'd6, 1'b1, 2'd0, 32'h200, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80};
    vecs[2]  = '{2'b01, 3'b100, 32'h103, 32'h0, 32'h80112233, 5'd7, 1'b1, 2'd0, 32'h200, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h00000080};
    vecs[3]  = '{2'b01, 3'b101, 32'h102, 32'h0, 32'h80112233, 5'd8, 1'b1, 2'd0, 32'h200, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h00008011};
    vecs[4]  = '{2'b01, 3'b001, 32'h102, 32'h0, 32'h80112233, 5'd9, 1'b1, 2'd0, 32'h200, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF8011};
    vecs[5]  = '{2'b10, 3'b000, 32'h101, 32'hAB, 32'h0, 5'd0, 1'b0, 2'd0, 32'h200, 1'b1, 1'b1, 4'b0010, 32'hABABABAB, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{2'b10, 3'b001, 32'h102, 32'h1234, 32'h0, 5'd0, 1'b0, 2'd0, 32'h200, 1'b1, 1'b1, 4'b1100, 32'h12341234, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{2'b10, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 5'd0, 1'b0, 2'd0, 32'h200, 1'b1, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{2'b00, 3'b010, 32'h55, 32'h0, 32'h0, 5'd11, 1'b1, 2'd1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h55};
    vecs[9]  = '{2'b00, 3'b000, 32'h1000, 32'h0, 32'h0, 5'd12, 1'b1, 2'd2, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h404};
    vecs[10] = '{2'b01, 3'b010, 32'h100, 32'h0, 32'h55AA55AA, 5'd0, 1'b1, 2'd0, 32'h200, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{2'b11, 3'b010, 32'h103, 32'h0, 32'h0, 5'd13, 1'b1, 2'd1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h103};
    vecs[12] = '{2'b01, 3'b010, 32'h102, 32'h0, 32'h0, 5'd10, 1'b1, 2'd0, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{2'b01, 3'b011, 32'h100, 32'h0, 32'h0, 5'd14, 1'b1, 2'd0, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 5'd15, 1'b1, 2'd3, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0};

    rst_n = 1'b0;
    drive('0, 1'b0);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_alu", mem_ALU_out, 32'h0);
    chk("rst_wbdata", wb_WBData, 32'h0);
    chk("rst_wbwen", 32'(wb_RegWEn), 32'h0);
    chk("rst_flags", {30'h0, mem_misalign, mem_timeout}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      drive(v, 1'b1);
      dmem_ready = 1'b0;
      if (v.expWen) expQ.push_back('{v.rd, v.expData});
      @(posedge clk); #1;
      ex_valid = 1'b0;
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(v.expReq));
      if (v.expReq) begin
        chk($sformatf("v%0d_addr", i), dmem_addr, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(v.expWe));
        if (v.expWe) begin
          chk($sformatf("v%0d_wstrb", i), 32'(dmem_wstrb), 32'(v.expStrb));
          chk($sformatf("v%0d_wdata", i), dmem_wdata, v.expWdata);
        end
      end
      chk($sformatf("v%0d_alu", i), mem_ALU_out, v.addr);
      chk($sformatf("v%0d_memwen", i), 32'(mem_RegWEn), 32'(v.regWEn));
      chk($sformatf("v%0d_misalign", i), 32'(mem_misalign), 32'(v.expMis));
      dmem_ready = v.expReq;
      dmem_rdata = v.rdata;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'h0);
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      chk($sformatf("v%0d_wbwen", i), 32'(wb_RegWEn), 32'(v.expWen));
    end

    // Invalid memory op with ready asserted while idle
    drive(mk(2'b01, 3'b010, 32'h100, 5'd19, 2'd0), 1'b0);
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    chk("inv_req", 32'(dmem_req), 32'h0);
    chk("inv_stall", 32'(mem_stall), 32'h0);
    chk("inv_memwen", 32'(mem_RegWEn), 32'h0);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    chk("inv_wbwen", 32'(wb_RegWEn), 32'h0);

    // Back-to-back loads, zero-wait memory
    drive(mk(2'b01, 3'b010, 32'h200, 5'd20, 2'd0), 1'b1);
    expQ.push_back('{5'd20, 32'h11111111});
    @(posedge clk); #1;
    drive(mk(2'b01, 3'b010, 32'h204, 5'd21, 2'd0), 1'b1);
    expQ.push_back('{5'd21, 32'h22222222});
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11111111;
    chk("b2b_req1", 32'(dmem_req), 32'h1);
    chk("b2b_addr1", dmem_addr, 32'h200);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    dmem_rdata = 32'h22222222;
    chk("b2b_req2", 32'(dmem_req), 32'h1);
    chk("b2b_addr2", dmem_addr, 32'h204);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    chk("b2b_idle", 32'(dmem_req), 32'h0);

    // Ready delayed 3 cycles behind a writing ALU op held in W
    drive(mk(2'b00, 3'b000, 32'h77, 5'd15, 2'd1), 1'b1);
    expQ.push_back('{5'd15, 32'h77});
    @(posedge clk); #1;
    drive(mk(2'b01, 3'b010, 32'h108, 5'd13, 2'd0), 1'b1);
    expQ.push_back('{5'd13, 32'hA5A5A5A5});
    @(posedge clk); #1;
    ex_valid = 1'b0;
    stallCnt = 0;
    for (int c = 0; c < 4; c++) begin
      dmem_ready = (c == 3);
      dmem_rdata = 32'hA5A5A5A5;
      #1;
      if (mem_stall) stallCnt++;
      chk($sformatf("dly%0d_addr", c), dmem_addr, 32'h108);
      chk($sformatf("dly%0d_alu", c), mem_ALU_out, 32'h108);
      chk($sformatf("dly%0d_req", c), 32'(dmem_req), 32'h1);
      chk($sformatf("dly%0d_whold", c), {26'h0, wb_RegWEn, wb_rd}, {26'h0, 1'b1, 5'd15});
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    chk("dly_stallcnt", 32'(stallCnt), 32'd3);

    // Memory never responds: timeout after MAX_WAIT=4 busy cycles
    chk("to_before", 32'(mem_timeout), 32'h0);
    drive(mk(2'b01, 3'b010, 32'h10C, 5'd16, 2'd0), 1'b1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    stallCnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (!mem_stall) break;
      stallCnt++;
      @(posedge clk); #1;
    end
    chk("to_stallcnt", 32'(stallCnt), 32'd3);
    chk("to_req_last", 32'(dmem_req), 32'h1);
    @(posedge clk); #1;
    chk("to_flag", 32'(mem_timeout), 32'h1);
    chk("to_wbwen", 32'(wb_RegWEn), 32'h0);
    chk("to_req_after", 32'(dmem_req), 32'h0);

    // Asynchronous reset in the middle of a busy access
    drive(mk(2'b01, 3'b010, 32'h110, 5'd17, 2'd0), 1'b1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rb_req", 32'(dmem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_req_drop", 32'(dmem_req), 32'h0);
    chk("rb_stall", 32'(mem_stall), 32'h0);
    chk("rb_flags", {30'h0, mem_misalign, mem_timeout}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rb_idle", 32'(dmem_req), 32'h0);

    drive(mk(2'b01, 3'b010, 32'h100, 5'd18, 2'd0), 1'b1);
    expQ.push_back('{5'd18, 32'h12345678});
    @(posedge clk); #1;
    ex_valid = 1'b0;
    dmem_ready = 1'b1;
    dmem_rdata = 32'h12345678;
    chk("post_req", 32'(dmem_req), 32'h1);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(expQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the 5-stage RV32I pipeline, sitting directly downstream of the execute unit. It holds the EX/MEM and MEM/WB pipeline registers and drives a data-memory request/ready handshake with byte/half/word alignment. It stalls upstream while memory is busy and returns `mem_ALU_out` and `wb_WBData` to the execute stage's forwarding muxes.

## Interface
- `MAX_WAIT`, default 15: number of consecutive BUSY cycles without `dmem_ready` before the access is aborted (≥2).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_ALU_out` in 32: ALU result / effective address.
- `ex_ForwardDataB` in 32: store data.
- `ex_MemOp` in 2: 00 none, 01 load, 10 store, 11 treated as none.
- `ex_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
- `ex_rd` in 5, `ex_RegWEn` in 1, `ex_WBSel` in 2, `ex_pc` in 32: writeback controls.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (word-aligned), `dmem_wdata` out 32, `dmem_wstrb` out 4.
- `dmem_rdata` in 32, `dmem_ready` in 1.
- `mem_stall` out 1: freezes PC, IF/ID and ID/EX.
- `mem_ALU_out` out 32: registered M-stage ALU result (forward source, sel 2).
- `mem_rd` out 5, `mem_RegWEn` out 1: M-stage destination for the forwarding unit.
- `wb_WBData` out 32, `wb_rd` out 5, `wb_RegWEn` out 1: register-file write port (forward source, sel 1).
- `mem_misalign` out 1, `mem_timeout` out 1: sticky error flags.

## Operation
- M register captures the EX bundle on every edge where `mem_stall`=0. `m_valid` is loaded from `ex_valid`.
- W register captures M on every edge where `mem_stall`=0. It holds while stalled, so the write repeats with the same value.
- FSM states:
  - IDLE→BUSY on a capture edge if `ex_valid`, the op is a load/store, and it is aligned.
  - BUSY→IDLE on the completion edge if the next captured op does not qualify.
  - BUSY→BUSY if the next op qualifies.
- `dmem_req` = (state==BUSY). Address, we, wdata and wstrb come from M regs and stay stable while BUSY.
- `dmem_addr` = {m_alu[31:2],2'b00}.
- Store wstrb: B 0001<<off; H 0011<<off; W 1111.
- Store wdata: B {4{b}}; H {2{h}}; W word.
- Load extract: B/BU select byte `off`; H/HU select half `off[1]`. B/H sign-extend, BU/HU zero-extend. Extracted value is latched into W on the completion edge.
- Alignment: H requires a[0]=0; W requires a[1:0]=0.
- Misaligned or illegal funct3 load/store:
  - No request is issued, and the instruction passes with RegWEn forced to 0 in W.
  - `mem_misalign` is set and held until reset.
- Timeout: a counter runs in BUSY. On the MAX_WAIT-th BUSY cycle without ready, the access completes as if ready, with load data 0 and W RegWEn forced to 0. `mem_timeout` is set sticky.
- `wb_WBData`: WBSel 0 load data, 1 ALU, 2 pc+4, 3 zero.
- `wb_RegWEn` = w_valid & w_RegWEn & (rd≠0).
- `mem_RegWEn` = m_valid & m_RegWEn.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0, flags cleared. Reset is asynchronous, so it aborts a BUSY access immediately and deasserts `dmem_req`.
- `mem_stall` = BUSY & !dmem_ready & !timeout_hit. It is combinational on `dmem_ready`.
- Zero-wait memory (ready in the first BUSY cycle): no stall cycles.
- N-cycle memory: N stall cycles.
- Load data appears on `wb_WBData` the cycle after the completion edge.
- Non-memory ops: one cycle per stage, with no FSM involvement.
- Back-to-back memory ops: the next request follows with no idle cycle between them.
- `ex_valid`=0 with a memory op: no request is issued.
- `dmem_ready` while IDLE is ignored.

## Test plan
- LW at address 0x100, ready at the first BUSY cycle, rdata 0xDEADBEEF, WBSel 0, rd 5 -> no stall; `wb_WBData`=0xDEADBEEF and `wb_RegWEn`=1 with `wb_rd`=5 two cycles after EX.
- LB at 0x103 with rdata 0x80112233 -> 0xFFFFFF80. LBU at 0x103 -> 0x00000080. LHU at 0x102 -> 0x00008011.
- SB at 0x101 with data 0x000000AB -> `dmem_wstrb`=0010, `dmem_wdata`=0xABABABAB, `dmem_we`=1, `dmem_addr`=0x100.
- Ready delayed 3 cycles -> `mem_stall` high exactly 3 cycles; `mem_ALU_out` and `dmem_*` stable throughout; W holds.
- LW at 0x102 -> no `dmem_req`; `mem_misalign`=1 sticky; `wb_RegWEn`=0.
- Ready never asserted with MAX_WAIT=4 -> stall for 3 cycles; `mem_timeout`=1; `wb_RegWEn`=0. Repeat with `rst_n` pulsed mid-BUSY -> `dmem_req`=0 and IDLE immediately.
